// File: rtl/mi_issue_buffer.sv
// Fetch-to-issue decoupling buffer for the multi-issue core.
// Holds up to DEPTH fetch bundles of ISSUE_NUM lanes each. Each lane of the
// head bundle is offered to its decoder via its own valid/ready handshake.
// A lane is held back while an older, still-pending lane of the same bundle
// writes a scalar register that the lane reads. The head retires once every
// non-empty lane has been accepted.
module mi_issue_buffer #(
    parameter int ISSUE_NUM = 2,
    parameter int INST_DW   = 32,
    parameter int INST_AW   = 32,
    parameter int DEPTH     = 4,
    parameter int REG_AW    = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fetch_valid_i,
    output logic                           fetch_ready_o,
    input  logic [INST_AW-1:0]             fetch_pc_i,
    input  logic [INST_DW*ISSUE_NUM-1:0]   fetch_inst_i,
    input  logic                           flush_i,
    output logic [ISSUE_NUM-1:0]           issue_valid_o,
    input  logic [ISSUE_NUM-1:0]           issue_ready_i,
    output logic [INST_DW*ISSUE_NUM-1:0]   issue_inst_o,
    output logic [INST_AW*ISSUE_NUM-1:0]   issue_pc_o,
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Opcodes used by the hazard decode
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_VEC    = 7'b1010111;

    // Bundle storage: data arrays carry no reset, pending bits do
    logic [INST_AW-1:0]           mem_pc   [DEPTH];
    logic [INST_DW*ISSUE_NUM-1:0] mem_inst [DEPTH];
    logic [ISSUE_NUM-1:0]         pending_all [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic                         head_present;
    logic [ISSUE_NUM-1:0]         head_pend;
    logic [INST_DW*ISSUE_NUM-1:0] head_inst;
    logic [INST_AW-1:0]           head_pc;
    logic [ISSUE_NUM-1:0]         enq_mask;
    logic [ISSUE_NUM-1:0]         handshake;
    logic [ISSUE_NUM-1:0]         lane_blocked;
    logic                         push;
    logic                         pop;

    // Per-lane decoded register usage of the head bundle
    logic [ISSUE_NUM-1:0] lane_wr;
    logic [ISSUE_NUM-1:0] lane_r1;
    logic [ISSUE_NUM-1:0] lane_r2;
    logic [REG_AW-1:0]    lane_rd  [ISSUE_NUM];
    logic [REG_AW-1:0]    lane_rs1 [ISSUE_NUM];
    logic [REG_AW-1:0]    lane_rs2 [ISSUE_NUM];

    assign head_present  = (count_reg != '0);
    assign head_pend     = pending_all[rd_ptr_reg];
    assign head_inst     = mem_inst[rd_ptr_reg];
    assign head_pc       = mem_pc[rd_ptr_reg];
    assign fetch_ready_o = (count_reg < DEPTH_C);
    assign count_o       = count_reg;
    assign push          = fetch_valid_i && fetch_ready_o;
    assign handshake     = issue_valid_o & issue_ready_i;
    // Head retires once nothing is left pending after this edge's handshakes
    assign pop           = head_present && ((head_pend & ~handshake) == '0);

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_NUM; gi++) begin : g_lane
            logic [INST_DW-1:0] inst;
            logic [6:0]         opc;
            logic [2:0]         f3;
            logic               rd_nz;

            assign inst  = head_inst[gi*INST_DW +: INST_DW];
            assign opc   = inst[6:0];
            assign f3    = inst[14:12];
            assign lane_rd[gi]  = inst[7 +: REG_AW];
            assign lane_rs1[gi] = inst[15 +: REG_AW];
            assign lane_rs2[gi] = inst[20 +: REG_AW];
            assign rd_nz = (inst[7 +: REG_AW] != '0);

            assign lane_wr[gi] = rd_nz &&
                ((opc == OP_REG) || (opc == OP_IMM) || (opc == OP_LOAD) ||
                 (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL) ||
                 (opc == OP_JALR));
            // Vector ops read a scalar rs1 only in the .vx form
            assign lane_r1[gi] =
                (opc == OP_REG) || (opc == OP_IMM) || (opc == OP_LOAD) ||
                (opc == OP_STORE) || (opc == OP_BRANCH) || (opc == OP_JALR) ||
                ((opc == OP_VEC) && (f3 == 3'b100));
            assign lane_r2[gi] =
                (opc == OP_REG) || (opc == OP_STORE) || (opc == OP_BRANCH);

            // An all-zero lane is an empty slot and is never marked pending
            assign enq_mask[gi] = |fetch_inst_i[gi*INST_DW +: INST_DW];

            assign issue_inst_o[gi*INST_DW +: INST_DW] =
                head_present ? inst : '0;
            assign issue_pc_o[gi*INST_AW +: INST_AW] =
                head_present ? (head_pc + INST_AW'(4 * gi)) : '0;
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ISSUE_NUM-1:0] pend_reg;

            // Pending bits: set on enqueue, cleared lane-by-lane on handshake
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pend_reg <= '0;
                end else if (flush_i) begin
                    pend_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    pend_reg <= enq_mask;
                end else if (head_present && (rd_ptr_reg == PTR_W'(gi))) begin
                    pend_reg <= pend_reg & ~handshake;
                end
            end

            assign pending_all[gi] = pend_reg;
        end
    endgenerate

    // Lane k waits while an older pending lane writes a register k reads.
    // Uses start-of-cycle pending, so a same-cycle issue does not unblock.
    always_comb begin
        lane_blocked  = '0;
        issue_valid_o = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            for (int j = 0; j < ISSUE_NUM; j++) begin
                if ((j < k) && head_pend[j] && lane_wr[j] &&
                    ((lane_r1[k] && (lane_rs1[k] == lane_rd[j])) ||
                     (lane_r2[k] && (lane_rs2[k] == lane_rd[j])))) begin
                    lane_blocked[k] = 1'b1;
                end
            end
            issue_valid_o[k] = head_present && head_pend[k] && !lane_blocked[k];
        end
    end

    // Pointer and occupancy next-state
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (!push && pop) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Bundle data write; a flush in the same cycle drops the enqueue
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_pc[wr_ptr_reg]   <= fetch_pc_i;
            mem_inst[wr_ptr_reg] <= fetch_inst_i;
        end
    end

endmodule

// File: tb/tb_mi_issue_buffer.sv
// Directed testbench for mi_issue_buffer (ISSUE_NUM=2, DEPTH=4).
module tb_mi_issue_buffer;

    logic        clk;
    logic        rst;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_pc_i;
    logic [63:0] fetch_inst_i;
    logic        flush_i;
    logic [1:0]  issue_valid_o;
    logic [1:0]  issue_ready_i;
    logic [63:0] issue_inst_o;
    logic [63:0] issue_pc_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] ADDI_X1   = 32'h00500093;
    localparam logic [31:0] VADD_VV   = 32'h02208057;
    localparam logic [31:0] ADDI_X5   = 32'h00100293;
    localparam logic [31:0] VADD_VX5  = 32'h0222C0D7;
    localparam logic [31:0] ADD_X6_X5 = 32'h00508333;

    mi_issue_buffer #(
        .ISSUE_NUM(2), .INST_DW(32), .INST_AW(32), .DEPTH(4), .REG_AW(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_valid_i(fetch_valid_i),
        .fetch_ready_o(fetch_ready_o),
        .fetch_pc_i(fetch_pc_i),
        .fetch_inst_i(fetch_inst_i),
        .flush_i(flush_i),
        .issue_valid_o(issue_valid_o),
        .issue_ready_i(issue_ready_i),
        .issue_inst_o(issue_inst_o),
        .issue_pc_o(issue_pc_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_valid", 64'(issue_valid_o), 64'd0);
        chk("reset_inst", issue_inst_o, 64'd0);
        chk("reset_pc", issue_pc_o, 64'd0);
        rst = 1'b1;
        step();
        chk("reset_fetch_ready", 64'(fetch_ready_o), 64'd1);
    endtask

    task automatic test_fill();
        issue_ready_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            fetch_valid_i = 1'b1;
            fetch_pc_i    = 32'h100 + 32'(8 * i);
            fetch_inst_i  = {VADD_VV, ADDI_X1};
            step();
        end
        chk("fill_count4", 64'(count_o), 64'd4);
        chk("fill_ready0", 64'(fetch_ready_o), 64'd0);
        fetch_pc_i = 32'h200;
        step();
        chk("fill_fifth_ignored", 64'(count_o), 64'd4);
        chk("fill_head_pc", issue_pc_o, {32'h104, 32'h100});
        fetch_valid_i = 1'b0;
        issue_ready_i = 2'b11;
        step();
        issue_ready_i = 2'b00;
        chk("fill_pop_count", 64'(count_o), 64'd3);
        chk("fill_next_pc", issue_pc_o, {32'h10C, 32'h108});
        // reset mid-operation discards everything at once
        rst = 1'b0;
        #1;
        chk("midreset_count", 64'(count_o), 64'd0);
        chk("midreset_valid", 64'(issue_valid_o), 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("midreset_after", 64'(count_o), 64'd0);
    endtask

    task automatic test_independent();
        issue_ready_i = 2'b11;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h1000;
        fetch_inst_i  = {VADD_VV, ADDI_X1};
        step();
        fetch_valid_i = 1'b0;
        chk("indep_valid", 64'(issue_valid_o), 64'd3);
        chk("indep_inst", issue_inst_o, {VADD_VV, ADDI_X1});
        chk("indep_pc", issue_pc_o, {32'h1004, 32'h1000});
        step();
        chk("indep_count0", 64'(count_o), 64'd0);
        chk("indep_valid0", 64'(issue_valid_o), 64'd0);
    endtask

    task automatic test_raw_hazard();
        issue_ready_i = 2'b00;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h2000;
        fetch_inst_i  = {VADD_VX5, ADDI_X5};
        step();
        fetch_valid_i = 1'b0;
        chk("raw_rs1_block", 64'(issue_valid_o), 64'd1);
        issue_ready_i = 2'b11;
        step();
        chk("raw_lane1_next", 64'(issue_valid_o), 64'd2);
        chk("raw_count_hold", 64'(count_o), 64'd1);
        step();
        chk("raw_pop", 64'(count_o), 64'd0);
        // rs2 dependency: add x6,x1,x5 behind addi x5
        issue_ready_i = 2'b00;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h2100;
        fetch_inst_i  = {ADD_X6_X5, ADDI_X5};
        step();
        fetch_valid_i = 1'b0;
        chk("raw_rs2_block", 64'(issue_valid_o), 64'd1);
        issue_ready_i = 2'b11;
        step();
        chk("raw_rs2_next", 64'(issue_valid_o), 64'd2);
        step();
        chk("raw_rs2_pop", 64'(count_o), 64'd0);
        // no dependency: addi x1 ahead of a .vx reading x5
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h2200;
        fetch_inst_i  = {VADD_VX5, ADDI_X1};
        step();
        fetch_valid_i = 1'b0;
        chk("raw_nodep", 64'(issue_valid_o), 64'd3);
        step();
        chk("raw_nodep_pop", 64'(count_o), 64'd0);
    endtask

    task automatic test_backpressure();
        issue_ready_i = 2'b10;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h3000;
        fetch_inst_i  = {VADD_VV, ADDI_X1};
        step();
        fetch_valid_i = 1'b0;
        chk("bp_both_valid", 64'(issue_valid_o), 64'd3);
        step();
        chk("bp_lane0_only", 64'(issue_valid_o), 64'd1);
        chk("bp_inst_lane0", 64'(issue_inst_o[31:0]), 64'(ADDI_X1));
        chk("bp_pc_lane0", 64'(issue_pc_o[31:0]), 64'h3000);
        chk("bp_count1", 64'(count_o), 64'd1);
        step();
        chk("bp_still_valid", 64'(issue_valid_o), 64'd1);
        chk("bp_inst_stable", 64'(issue_inst_o[31:0]), 64'(ADDI_X1));
        issue_ready_i = 2'b11;
        step();
        chk("bp_pop", 64'(count_o), 64'd0);
    endtask

    task automatic test_flush();
        issue_ready_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            fetch_valid_i = 1'b1;
            fetch_pc_i    = 32'h4000 + 32'(8 * i);
            fetch_inst_i  = {VADD_VV, ADDI_X1};
            step();
        end
        chk("flush_pre_count", 64'(count_o), 64'd3);
        fetch_pc_i = 32'h4100;
        flush_i    = 1'b1;
        step();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        chk("flush_count0", 64'(count_o), 64'd0);
        chk("flush_valid0", 64'(issue_valid_o), 64'd0);
        chk("flush_ready1", 64'(fetch_ready_o), 64'd1);
        step();
        chk("flush_not_stored", 64'(count_o), 64'd0);
    endtask

    task automatic test_back_to_back_wrap();
        logic [31:0] inst0;
        issue_ready_i = 2'b11;
        for (int i = 0; i < 10; i++) begin
            inst0 = 32'h00000093 | (32'(i) << 20);
            fetch_valid_i = 1'b1;
            fetch_pc_i    = 32'h80000000 + 32'(8 * i);
            fetch_inst_i  = {32'h0, inst0};
            step();
            chk($sformatf("wrap%0d_valid", i), 64'(issue_valid_o), 64'd1);
            chk($sformatf("wrap%0d_pc", i), 64'(issue_pc_o[31:0]), 64'(32'h80000000 + 32'(8 * i)));
            chk($sformatf("wrap%0d_inst", i), 64'(issue_inst_o[31:0]), 64'(inst0));
        end
        fetch_valid_i = 1'b0;
        begin
            int n = 0;
            while (count_o != 3'd0 && n < 20) begin
                step();
                n++;
            end
            checks++;
            if (count_o !== 3'd0) begin
                errors++;
                $display("FAIL wrap_drain: count %0d expected 0 within 20 cycles", count_o);
            end else begin
                $display("ok   wrap_drain: count 0");
            end
        end
    endtask

    initial begin
        rst           = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_pc_i    = '0;
        fetch_inst_i  = '0;
        flush_i       = 1'b0;
        issue_ready_i = 2'b00;
        test_reset();
        test_fill();
        test_independent();
        test_raw_hazard();
        test_backpressure();
        test_flush();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
